aes_key_expand: RTL and testbench
=================================

# aes_key_expand

On-the-fly AES-128 key schedule feeding the AddRoundKey byte slices. It loads a 128-bit cipher key and holds one round key at a time. Each `rk_next` request advances it to the next round key, one round per cycle, through round 10. Its `rk` word is split into the sixteen 8-bit `w_i` inputs of the `aes_xor` slices, so no 176-byte key table is stored.

## Interface
- No parameters. Fixed at AES-128: Nk=4, 10 rounds.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `ld`  in  1  single-cycle load strobe; samples `key` and restarts the schedule.
- `key`  in  128  cipher key; `key[127:96]` is word w0.
- `rk_next`  in  1  consumer request to advance to the next round key.
- `rk`  out  128  current round key; `rk[127:120]` is byte 0 in FIPS-197 order.
- `rk_round`  out  4  index of the round key currently on `rk`, 0..10.
- `rk_valid`  out  1  `rk` holds a valid round key.
- `rk_last`  out  1  `rk_round`==10 and `rk_valid`.

## Operation
- States:
  - IDLE: after reset, `rk_valid`=0.
  - RUN: `rk_valid`=1.
- Transitions:
  - IDLE→RUN on `ld`.
  - RUN→RUN on `ld`, which restarts from the new key.
  - No exit from RUN except `rst` low.
- Load: `rk`←`key`, `rk_round`←0, `rcon`←8'h01.
- Advance: taken when in RUN and `rk_next`=1 and `rk_round`<10.
  - temp = SubWord(RotWord(`rk[31:0]`)) ^ {`rcon`, 24'h0}.
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - `rk_round` increments by 1.
  - `rcon` ← xtime(`rcon`), i.e. {`rcon[6:0]`,1'b0} ^ (`rcon[7]` ? 8'h1b : 8'h00).
  - `rcon` sequence: 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses four instances of the codebase's combinational `aes_sbox`. The whole round is a single combinational step from registered `rk`.
- `rk_next` with `rk_round`==10: ignored. `rk`, `rk_round` and `rk_last` hold.
- `rk_next` in IDLE: ignored.
- `ld` and `rk_next` in the same cycle: `ld` wins; the advance is discarded.
- `rk` is a plain register. It is not cleared on completion and holds until the next `ld` or reset.

## Timing
- Reset: `rst`=0 at an edge gives `rk`=0, `rk_round`=0, `rcon`=8'h01, `rk_valid`=0, `rk_last`=0 after that edge.
  - Reset mid-schedule aborts immediately.
  - `ld` in the same cycle as `rst`=0 is ignored.
- Load latency: `ld` sampled at edge N gives `rk`=`key`, `rk_round`=0 and `rk_valid`=1 after edge N.
- Advance latency: one cycle. `rk_next` sampled at edge N gives round r+1 on `rk` after edge N.
  - Back-to-back `rk_next` gives one round per cycle.
  - From `ld`, round 10 is reached after 11 edges (1 load + 10 advances).
- `rk_last` is registered and asserts in the same cycle `rk_round` becomes 10.
- Consumer contract: the `aes_xor` slice samples `w_i` while `rk` is stable. The round key on `rk` during cycle N is the key for the round being computed in cycle N. The consumer asserts `rk_next` in the cycle it consumes a key.
- All outputs change only on the rising edge of `clk`; there are no combinational input→output paths.

## Test plan
- FIPS-197 A.1 load: `ld`, `key`=2b7e151628aed2a6abf7158809cf4f3c → next cycle `rk`=same value, `rk_round`=0, `rk_valid`=1, `rk_last`=0.
- Full schedule: after the FIPS load, 10 consecutive `rk_next` pulses → after the 1st, `rk`=a0fafe1788542cb123a339392a6c7605. After the 10th, `rk`=d014f9a8c9ee2589e13f0cc8b6630ca6, `rk_round`=10, `rk_last`=1.
- Zero key, gapped requests: `key`=0, `rk_next` every 3rd cycle → round 1 `rk`=62636363626363636263636362636363. `rk` holds between requests.
- Saturation and priority:
  - Extra `rk_next` at round 10 → `rk` unchanged, `rk_round`=10.
  - `ld`+`rk_next` in the same cycle → `rk`=new key, `rk_round`=0.
- Reset: `rst`=0 at round 5 → next cycle all outputs 0, `rk_valid`=0. `rk_next` while in IDLE → no change.
- Reload mid-run: new `ld` at round 4 with the zero key → `rk_round`=0. The following `rk_next` gives the 62636363… key, confirming `rcon` restarted at 01.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if: round-key handshake between the key schedule and its
// AddRoundKey consumer.
//   ld       : load strobe (consumer -> schedule)
//   key      : 128-bit cipher key, key[127:96] is word w0
//   rk_next  : advance request
//   rk       : current round key, rk[127:120] is byte 0
//   rk_round : index of round key on rk, 0..10
//   rk_valid : rk holds a valid round key
//   rk_last  : round 10 is on rk
interface aes_key_expand_if;
    logic         ld;
    logic [127:0] key;
    logic         rk_next;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_last;

    modport master (output ld, key, rk_next, input rk, rk_round, rk_valid, rk_last);
    modport slave  (input ld, key, rk_next, output rk, rk_round, rk_valid, rk_last);
endinterface

// File: rtl/aes_key_expand.sv
// aes_key_expand: on-the-fly AES-128 key schedule. Holds one round key at a
// time and advances one round per rk_next, through round 10.
//   clk_i  : clock, all state changes on rising edge
//   rst_ni : synchronous active-low reset
//   kx     : aes_key_expand_if.slave (ld/key/rk_next in, rk/rk_round/rk_valid/rk_last out)

// aes_sbox: combinational AES S-box, GF(2^8) inverse followed by the affine map.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
    end

    assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expand (
    input  logic              clk_i,
    input  logic              rst_ni,
    aes_key_expand_if.slave   kx
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         last_q, last_d;

    // SubWord(RotWord(w3)) from the registered key; RotWord moves byte 0 to the end
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  temp;
    logic [31:0]  w0n, w1n, w2n, w3n;

    assign rot_w = {rk_q[23:0], rk_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a_i(rot_w[8*b +: 8]), .s_o(sub_w[8*b +: 8]));
    end

    assign temp = sub_w ^ {rcon_q, 24'h0};
    assign w0n  = rk_q[127:96] ^ temp;
    assign w1n  = rk_q[95:64]  ^ w0n;
    assign w2n  = rk_q[63:32]  ^ w1n;
    assign w3n  = rk_q[31:0]   ^ w2n;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        last_d  = last_q;
        // ld has priority over rk_next in both states; rk_next in IDLE is dropped
        if (kx.ld) begin
            state_d = RUN;
            rk_d    = kx.key;
            round_d = 4'd0;
            rcon_d  = 8'h01;
            last_d  = 1'b0;
        end else if (state_q == RUN && kx.rk_next && round_q != 4'd10) begin
            rk_d    = {w0n, w1n, w2n, w3n};
            round_d = round_q + 4'd1;
            rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            last_d  = (round_q == 4'd9);
        end
    end

    assign kx.rk       = rk_q;
    assign kx.rk_round = round_q;
    assign kx.rk_valid = (state_q == RUN);
    assign kx.rk_last  = last_q;
endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;
    typedef struct {
        logic [127:0] rk;
        logic [3:0]   rnd;
        logic         vld;
        logic         last;
    } exp_t;

    typedef struct {
        logic         ld;
        logic         nxt;
        logic [127:0] key;
        exp_t         e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    aes_key_expand_if bus();

    aes_key_expand dut (.clk_i(clk), .rst_ni(rst_n), .kx(bus));

    always #5 clk = ~clk;

    localparam logic [127:0] FK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] fips [0:10];
    logic [127:0] zk [0:2];

    function automatic exp_t mk(logic [127:0] rk, logic [3:0] rnd, logic vld, logic last);
        exp_t e;
        e.rk = rk; e.rnd = rnd; e.vld = vld; e.last = last;
        return e;
    endfunction

    task automatic check(string nm, exp_t e);
        n_tests++;
        if (bus.rk !== e.rk || bus.rk_round !== e.rnd || bus.rk_valid !== e.vld || bus.rk_last !== e.last) begin
            n_fail++;
            $display("FAIL %s: got rk=%h rnd=%0d vld=%b last=%b, want rk=%h rnd=%0d vld=%b last=%b",
                     nm, bus.rk, bus.rk_round, bus.rk_valid, bus.rk_last, e.rk, e.rnd, e.vld, e.last);
        end
    endtask

    // drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic drive(string nm, logic ld, logic nxt, logic [127:0] k, exp_t e);
        bus.ld = ld; bus.rk_next = nxt; bus.key = k;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.ld = 1'b0; bus.rk_next = 1'b0;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            check(nm, sb.pop_front());
        end
    endtask

    vec_t vt[$];

    initial begin
        fips[0]  = FK;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zk[0] = '0;
        zk[1] = 128'h62636363626363636263636362636363;
        zk[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

        // FIPS load, full schedule, saturation at 10, ld+rk_next priority
        vt.push_back('{1'b1, 1'b0, FK, mk(fips[0], 4'd0, 1'b1, 1'b0)});
        for (int r = 1; r <= 10; r++)
            vt.push_back('{1'b0, 1'b1, '0, mk(fips[r], 4'(r), 1'b1, r == 10)});
        vt.push_back('{1'b0, 1'b1, '0, mk(fips[10], 4'd10, 1'b1, 1'b1)});
        vt.push_back('{1'b0, 1'b0, '0, mk(fips[10], 4'd10, 1'b1, 1'b1)});
        vt.push_back('{1'b1, 1'b1, '0, mk(zk[0], 4'd0, 1'b1, 1'b0)});
        vt.push_back('{1'b0, 1'b1, '0, mk(zk[1], 4'd1, 1'b1, 1'b0)});

        bus.ld = 1'b0; bus.rk_next = 1'b0; bus.key = '0;
        rst_n = 1'b0;
        #1;
        drive("reset", 1'b0, 1'b0, '0, mk('0, 4'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        drive("idle_next", 1'b0, 1'b1, '0, mk('0, 4'd0, 1'b0, 1'b0));

        foreach (vt[i])
            drive($sformatf("vec%0d", i), vt[i].ld, vt[i].nxt, vt[i].key, vt[i].e);

        // zero key, rk_next every 3rd cycle; rk must hold in the gaps
        drive("zero_ld", 1'b1, 1'b0, '0, mk(zk[0], 4'd0, 1'b1, 1'b0));
        for (int r = 1; r <= 2; r++) begin
            drive($sformatf("gap_adv%0d", r), 1'b0, 1'b1, '0, mk(zk[r], 4'(r), 1'b1, 1'b0));
            for (int h = 0; h < 2; h++)
                drive($sformatf("gap_hold%0d_%0d", r, h), 1'b0, 1'b0, '0, mk(zk[r], 4'(r), 1'b1, 1'b0));
        end

        // reset at round 5, with ld asserted in the reset cycle (ignored)
        drive("rst_ld", 1'b1, 1'b0, FK, mk(fips[0], 4'd0, 1'b1, 1'b0));
        for (int r = 1; r <= 5; r++)
            drive($sformatf("rst_adv%0d", r), 1'b0, 1'b1, '0, mk(fips[r], 4'(r), 1'b1, 1'b0));
        rst_n = 1'b0;
        drive("mid_reset", 1'b1, 1'b1, FK, mk('0, 4'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        drive("idle_next2", 1'b0, 1'b1, '0, mk('0, 4'd0, 1'b0, 1'b0));

        // reload at round 4 with zero key; rcon must restart at 01
        drive("rl_ld", 1'b1, 1'b0, FK, mk(fips[0], 4'd0, 1'b1, 1'b0));
        for (int r = 1; r <= 4; r++)
            drive($sformatf("rl_adv%0d", r), 1'b0, 1'b1, '0, mk(fips[r], 4'(r), 1'b1, 1'b0));
        drive("rl_zero", 1'b1, 1'b0, '0, mk(zk[0], 4'd0, 1'b1, 1'b0));
        drive("rl_adv_z1", 1'b0, 1'b1, '0, mk(zk[1], 4'd1, 1'b1, 1'b0));
        drive("rl_adv_z2", 1'b0, 1'b1, '0, mk(zk[2], 4'd2, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
